wb_bram_arbiter: RTL and testbench
==================================

Name: wb_bram_arbiter

Overview:
- Shares one BRAM slave port between M Wishbone masters, for example a CPU data port and an NI DMA engine.
- The single slave-side Wishbone port drives the existing BRAM controller in either burst or non-burst mode.
- Grants are round-robin, registered and held for a whole bus cycle, including bursts.
- A beat counter bounds how long any one master can hold the memory.

Parameters:
M, 2, number of masters (2..8)
Dw, 32, data width
Aw, 10, word address width
SELw, Dw/8, byte-select width
CTIw, 3, cycle-type width
BTEw, 2, burst-type width
MAX_BEATS, 16, acked beats after which the grant is forcibly released at the next cycle boundary if another master is requesting

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
m_dat_i  in  M*Dw  master write data, master i at slice i
m_sel_i  in  M*SELw  master byte selects
m_addr_i  in  M*Aw  master word addresses
m_cti_i  in  M*CTIw  master cycle type
m_bte_i  in  M*BTEw  master burst type
m_stb_i  in  M  master strobes
m_cyc_i  in  M  master cycle flags
m_we_i  in  M  master write enables
m_dat_o  out  Dw  read data, broadcast to all masters
m_ack_o  out  M  per-master acknowledge
m_err_o  out  M  per-master error
m_rty_o  out  M  per-master retry
s_dat_o, s_sel_o, s_addr_o, s_cti_o, s_bte_o  out  Dw/SELw/Aw/CTIw/BTEw  to BRAM controller
s_stb_o, s_cyc_o, s_we_o  out  1  to BRAM controller
s_dat_i  in  Dw  read data from BRAM controller
s_ack_i, s_err_i, s_rty_i  in  1  responses from BRAM controller
grant_o  out  M  one-hot registered grant; all zero when idle

Behaviour:
- Clock clk; reset is synchronous, active-high.
- Reset values:
  - state=IDLE, grant_o=0, rr pointer=0, beat counter=0.
  - s_stb_o, s_cyc_o, s_we_o = 0; m_ack_o, m_err_o, m_rty_o = 0.
  - Data, address and select outputs are don't-care but driven from master 0.
- Request: req[i] = m_cyc_i[i] & m_stb_i[i].
- IDLE state:
  - If any req, register a one-hot grant chosen round-robin, starting the search at the pointer; go to BUSY.
  - Arbitration latency is 1 cycle; slave signals are not asserted during the IDLE cycle.
- BUSY state:
  - s_* = granted master's signals.
  - s_cyc_o = m_cyc_i[g]; s_stb_o = m_stb_i[g].
  - m_ack_o[g] = s_ack_i, likewise err and rty; all other masters see 0.
  - m_dat_o = s_dat_i unconditionally.
- Beat counter:
  - Increments on each s_ack_i in BUSY, saturating at MAX_BEATS.
  - Clears on entry to BUSY.
- Cycle boundary: m_cyc_i[g]=0, or s_ack_i with s_cti_o in {000, 111}.
- Release from BUSY to GAP happens on either:
  - m_cyc_i[g] falling; or
  - a cycle boundary while beat counter ≥ MAX_BEATS-1 (counting this ack) and another req is pending.
- Never release mid-burst (cti 001/010 without 111). A burst longer than MAX_BEATS completes, then is released.
- On release:
  - grant_o clears and the pointer becomes g+1 mod M.
  - s_stb_o and s_cyc_o are forced 0 in the release cycle's successor.
- GAP state:
  - One dead cycle with stb and cyc low, so the BRAM controller's registered ack and its state machine return to idle.
  - Then go to IDLE; arbitration for the next master happens in IDLE, so a new grant appears no earlier than 2 cycles after release.
- cti=100 (NI reserved) passes through unchanged and counts as a non-boundary beat.
- Simultaneous requests at IDLE: the lowest index at or after the pointer wins.
- Granted master drops cyc in the same cycle as an ack: the ack is still routed to it, then release.
- Reset mid-burst: grant aborts immediately, no ack is forwarded, and the pointer returns to 0.
- A master that raises stb without cyc is ignored.

Decomposition:
- Shared package wb_pkg:
  - CTI constants: CTI_CLASSIC=000, CTI_CONST=001, CTI_INC=010, CTI_NI=100, CTI_END=111.
  - BTE constants: LINEAR, FOUR, EIGHT, SIXTEEN.
  - State encoding: IDLE, BUSY, GAP.
- Sub-module arbiter_rr_onehot (M): inputs req, ptr, en; output one-hot gnt. Purely combinational search, with the pointer register held in the parent.

Test Plan:
- Single master 0 classic read, addr 0x005, cti=000: grant_o=01 one cycle after request; the s_ack_i pulse is forwarded only to m_ack_o[0]; release; s_stb_o low for one GAP cycle.
- Both masters request in the same cycle after reset: master 0 granted first; after it drops cyc, master 1 granted exactly 2 cycles after release; the pointer then favours master 0.
- Master 0 does a 4-beat incrementing burst (cti 010,010,010,111, bte=01) while master 1 waits: no release until the 111 ack; master 1 sees zero acks throughout.
- MAX_BEATS=4, master 0 issues back-to-back classic cycles holding cyc high, master 1 requesting: master 0 is forced off after its 4th ack; master 1 is granted next.
- Reset asserted in the 2nd beat of a burst: next cycle grant_o=0, s_cyc_o=0, m_ack_o=0; after reset, master 1 alone is granted normally.
- s_err_i asserted during master 1's grant: only m_err_o[1]=1; the grant is held until cyc drops.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: cycle-type and burst-type codes, and the
// state encoding used by the BRAM arbiter.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_NI      = 3'b100;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_FOUR    = 2'b01;
    localparam logic [1:0] BTE_EIGHT   = 2'b10;
    localparam logic [1:0] BTE_SIXTEEN = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    // An acked beat with one of these cycle types closes a bus cycle.
    function automatic logic cti_is_boundary(input logic [2:0] cti);
        return (cti == CTI_CLASSIC) || (cti == CTI_END);
    endfunction

endpackage

// File: rtl/arbiter_rr_onehot.sv
// Combinational round-robin search: the first requester at or after ptr
// wins. The pointer register lives in the parent.
module arbiter_rr_onehot #(
    parameter int M  = 2,
    parameter int PW = (M > 1) ? $clog2(M) : 1
) (
    input  logic [M-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [M-1:0]  gnt
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < M; k++) begin
            idx = PW'((int'(ptr) + k) % M);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_bram_arbiter.sv
// Round-robin arbiter sharing one BRAM Wishbone slave port between M masters,
// holding each grant for a whole bus cycle with a bounded beat budget.
module wb_bram_arbiter
    import wb_pkg::*;
#(
    parameter int M         = 2,
    parameter int Dw        = 32,
    parameter int Aw        = 10,
    parameter int SELw      = Dw / 8,
    parameter int CTIw      = 3,
    parameter int BTEw      = 2,
    parameter int MAX_BEATS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [M*Dw-1:0]   m_dat_i,
    input  logic [M*SELw-1:0] m_sel_i,
    input  logic [M*Aw-1:0]   m_addr_i,
    input  logic [M*CTIw-1:0] m_cti_i,
    input  logic [M*BTEw-1:0] m_bte_i,
    input  logic [M-1:0]      m_stb_i,
    input  logic [M-1:0]      m_cyc_i,
    input  logic [M-1:0]      m_we_i,
    output logic [Dw-1:0]     m_dat_o,
    output logic [M-1:0]      m_ack_o,
    output logic [M-1:0]      m_err_o,
    output logic [M-1:0]      m_rty_o,
    output logic [Dw-1:0]     s_dat_o,
    output logic [SELw-1:0]   s_sel_o,
    output logic [Aw-1:0]     s_addr_o,
    output logic [CTIw-1:0]   s_cti_o,
    output logic [BTEw-1:0]   s_bte_o,
    output logic              s_stb_o,
    output logic              s_cyc_o,
    output logic              s_we_o,
    input  logic [Dw-1:0]     s_dat_i,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    input  logic              s_rty_i,
    output logic [M-1:0]      grant_o
);

    localparam int PW = (M > 1) ? $clog2(M) : 1;
    localparam int BW = $clog2(MAX_BEATS + 1);

    arb_state_t    state, state_d;
    logic [M-1:0]  grant_q, grant_d, req, arb_gnt;
    logic [PW-1:0] ptr_q, ptr_d, gidx;
    logic [BW-1:0] beat_q, beat_d;
    logic          fwd, other_req, release_now;

    assign req = m_cyc_i & m_stb_i;

    arbiter_rr_onehot #(.M(M), .PW(PW)) u_rr (
        .req (req),
        .ptr (ptr_q),
        .en  (state == IDLE),
        .gnt (arb_gnt)
    );

    // With no grant the index falls back to master 0.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < M; i++) begin
            if (grant_q[i]) gidx = PW'(i);
        end
    end

    // Responses and strobes are suppressed while reset is asserted so an
    // interrupted burst never sees a stray ack.
    assign fwd = (state == BUSY) && !reset;

    assign s_dat_o  = m_dat_i[int'(gidx)*Dw +: Dw];
    assign s_sel_o  = m_sel_i[int'(gidx)*SELw +: SELw];
    assign s_addr_o = m_addr_i[int'(gidx)*Aw +: Aw];
    assign s_cti_o  = m_cti_i[int'(gidx)*CTIw +: CTIw];
    assign s_bte_o  = m_bte_i[int'(gidx)*BTEw +: BTEw];
    assign s_cyc_o  = fwd & m_cyc_i[gidx];
    assign s_stb_o  = fwd & m_stb_i[gidx];
    assign s_we_o   = fwd & m_we_i[gidx];

    assign m_dat_o = s_dat_i;
    assign m_ack_o = {M{fwd & s_ack_i}} & grant_q;
    assign m_err_o = {M{fwd & s_err_i}} & grant_q;
    assign m_rty_o = {M{fwd & s_rty_i}} & grant_q;
    assign grant_o = grant_q;

    assign other_req   = |(req & ~grant_q);
    assign release_now = !m_cyc_i[gidx] ||
                         (s_ack_i && cti_is_boundary(s_cti_o) &&
                          (beat_q >= BW'(MAX_BEATS - 1)) && other_req);

    always_comb begin
        state_d = state;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_d = BUSY;
                    grant_d = arb_gnt;
                    beat_d  = '0;
                end
            end
            BUSY: begin
                if (s_ack_i && (beat_q != BW'(MAX_BEATS))) beat_d = beat_q + 1'b1;
                if (release_now) begin
                    state_d = GAP;
                    grant_d = '0;
                    ptr_d   = (gidx == PW'(M - 1)) ? '0 : gidx + 1'b1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
        end else begin
            state   <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// Self-checking bench for wb_bram_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against an ownership model.
module tb_wb_bram_arbiter;
    import wb_pkg::*;

    localparam int M    = 2;
    localparam int Dw   = 32;
    localparam int Aw   = 10;
    localparam int SELw = Dw / 8;
    localparam int CTIw = 3;
    localparam int BTEw = 2;
    localparam int MAXB = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [M*Dw-1:0]   m_dat = '0;
    logic [M*SELw-1:0] m_sel = '0;
    logic [M*Aw-1:0]   m_addr = '0;
    logic [M*CTIw-1:0] m_cti = '0;
    logic [M*BTEw-1:0] m_bte = '0;
    logic [M-1:0]      m_stb = '0, m_cyc = '0, m_we = '0;
    logic [Dw-1:0]     s_dat = '0;
    logic              s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;

    logic [Dw-1:0]   m_dat_o, s_dat_o;
    logic [M-1:0]    m_ack_o, m_err_o, m_rty_o, grant_o;
    logic [SELw-1:0] s_sel_o;
    logic [Aw-1:0]   s_addr_o;
    logic [CTIw-1:0] s_cti_o;
    logic [BTEw-1:0] s_bte_o;
    logic            s_stb_o, s_cyc_o, s_we_o;

    wb_bram_arbiter #(.M(M), .Dw(Dw), .Aw(Aw), .SELw(SELw), .CTIw(CTIw),
                      .BTEw(BTEw), .MAX_BEATS(MAXB)) dut (
        .clk(clk), .reset(reset),
        .m_dat_i(m_dat), .m_sel_i(m_sel), .m_addr_i(m_addr), .m_cti_i(m_cti),
        .m_bte_i(m_bte), .m_stb_i(m_stb), .m_cyc_i(m_cyc), .m_we_i(m_we),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_addr_o(s_addr_o), .s_cti_o(s_cti_o),
        .s_bte_o(s_bte_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_we_o(s_we_o),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the bus, how many dead cycles remain before the next
    // arbitration, the round-robin pointer and the acked-beat count.
    int           md_own = -1;
    int           md_dead = 0;
    int           md_ptr = 0;
    int           md_beats = 0;
    logic [M-1:0] md_req, e_g;
    logic [2:0]   md_cti;
    bit           md_act, md_others;

    always @(negedge clk) begin
        if (chk_en) begin
            e_g    = (md_own >= 0) ? (M'(1) << md_own) : '0;
            md_act = (md_own >= 0) && !reset;
            check("grant_o", grant_o, e_g);
            check("m_dat_o", m_dat_o, s_dat);
            if (md_act) begin
                check("s_cyc_o", s_cyc_o, m_cyc[md_own]);
                check("s_stb_o", s_stb_o, m_stb[md_own]);
                check("s_we_o", s_we_o, m_we[md_own]);
                check("s_addr_o", s_addr_o, m_addr[md_own*Aw +: Aw]);
                check("s_dat_o", s_dat_o, m_dat[md_own*Dw +: Dw]);
                check("s_sel_o", s_sel_o, m_sel[md_own*SELw +: SELw]);
                check("s_cti_o", s_cti_o, m_cti[md_own*CTIw +: CTIw]);
                check("s_bte_o", s_bte_o, m_bte[md_own*BTEw +: BTEw]);
                check("m_ack_o", m_ack_o, s_ack ? e_g : '0);
                check("m_err_o", m_err_o, s_err ? e_g : '0);
                check("m_rty_o", m_rty_o, s_rty ? e_g : '0);
            end else begin
                check("s_cyc_o idle", s_cyc_o, 0);
                check("s_stb_o idle", s_stb_o, 0);
                check("s_we_o idle", s_we_o, 0);
                check("m_ack_o idle", m_ack_o, 0);
                check("m_err_o idle", m_err_o, 0);
                check("m_rty_o idle", m_rty_o, 0);
            end
        end
        md_req = m_cyc & m_stb;
        if (reset) begin
            md_own = -1; md_dead = 0; md_ptr = 0; md_beats = 0;
        end else if (md_own >= 0) begin
            if (s_ack && md_beats < MAXB) md_beats++;
            md_cti    = m_cti[md_own*CTIw +: 3];
            md_others = (md_req & ~(M'(1) << md_own)) != '0;
            if (!m_cyc[md_own] ||
                (s_ack && (md_cti == CTI_CLASSIC || md_cti == CTI_END) &&
                 md_beats >= MAXB && md_others)) begin
                md_ptr  = (md_own + 1) % M;
                md_own  = -1;
                md_dead = 1;
            end
        end else if (md_dead > 0) begin
            md_dead--;
        end else if (md_req != '0) begin
            for (int k = 0; k < M; k++) begin
                if (md_own < 0 && md_req[(md_ptr + k) % M]) md_own = (md_ptr + k) % M;
            end
            md_beats = 0;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                         input logic [Aw-1:0] a, input logic [2:0] cti, input logic [1:0] bte);
        m_cyc[i] = cyc;
        m_stb[i] = stb;
        m_we[i]  = we;
        m_addr[i*Aw +: Aw]       = a;
        m_cti[i*CTIw +: CTIw]    = cti;
        m_bte[i*BTEw +: BTEw]    = bte;
        m_dat[i*Dw +: Dw]        = $urandom;
        m_sel[i*SELw +: SELw]    = 4'hF;
    endtask

    task automatic set_s(input logic ack, input logic err, input logic rty);
        s_ack = ack; s_err = err; s_rty = rty;
        s_dat = $urandom;
    endtask

    task automatic do_reset();
        for (int i = 0; i < M; i++) set_m(i, 0, 0, 0, '0, CTI_CLASSIC, BTE_LINEAR);
        set_s(0, 0, 0);
        reset = 1'b1;
        nxt();
        nxt();
        reset = 1'b0;
    endtask

    logic [2:0] cti_tab [5] = '{CTI_CLASSIC, CTI_CONST, CTI_INC, CTI_NI, CTI_END};

    initial begin
        do_reset();
        chk_en = 1'b1;
        #1;
        check("rst grant_o", grant_o, 2'b00);
        check("rst s_cyc_o", s_cyc_o, 0);
        check("rst m_ack_o", m_ack_o, 2'b00);

        // Single classic read from master 0.
        set_m(0, 1, 1, 0, 10'h005, CTI_CLASSIC, BTE_LINEAR);
        #1;
        check("idle s_stb_o", s_stb_o, 0);
        nxt();
        set_s(1, 0, 0);
        #1;
        check("cls grant_o", grant_o, 2'b01);
        check("cls s_addr_o", s_addr_o, 10'h005);
        check("cls m_ack_o", m_ack_o, 2'b01);
        nxt();
        set_m(0, 0, 0, 0, 10'h005, CTI_CLASSIC, BTE_LINEAR);
        set_s(0, 0, 0);
        nxt();
        #1;
        check("gap grant_o", grant_o, 2'b00);
        check("gap s_stb_o", s_stb_o, 0);
        nxt();
        set_m(0, 0, 1, 0, 10'h001, CTI_CLASSIC, BTE_LINEAR);
        nxt();
        nxt();
        #1;
        check("stb_no_cyc grant_o", grant_o, 2'b00);

        // Simultaneous requests: master 0 first, master 1 two cycles after release.
        do_reset();
        set_m(0, 1, 1, 0, 10'h020, CTI_CLASSIC, BTE_LINEAR);
        set_m(1, 1, 1, 1, 10'h030, CTI_CLASSIC, BTE_LINEAR);
        nxt();
        #1;
        check("both grant_o", grant_o, 2'b01);
        set_s(1, 0, 0);
        nxt();
        set_m(0, 0, 0, 0, 10'h020, CTI_CLASSIC, BTE_LINEAR);
        set_s(0, 0, 0);
        nxt();
        #1;
        check("rel+1 grant_o", grant_o, 2'b00);
        nxt();
        #1;
        check("rel+2 grant_o", grant_o, 2'b00);
        nxt();
        #1;
        check("rel+3 grant_o", grant_o, 2'b10);
        set_m(1, 0, 0, 0, 10'h030, CTI_CLASSIC, BTE_LINEAR);
        set_m(0, 1, 1, 0, 10'h021, CTI_CLASSIC, BTE_LINEAR);
        nxt();
        set_m(1, 1, 1, 0, 10'h031, CTI_CLASSIC, BTE_LINEAR);
        nxt();
        nxt();
        #1;
        check("rr back grant_o", grant_o, 2'b01);

        // Four-beat incrementing burst while master 1 waits.
        do_reset();
        set_m(0, 1, 1, 0, 10'h010, CTI_INC, BTE_FOUR);
        set_m(1, 1, 1, 0, 10'h040, CTI_CLASSIC, BTE_LINEAR);
        nxt();
        for (int b = 0; b < 4; b++) begin
            set_m(0, 1, 1, 0, 10'h010 + 10'(b), (b == 3) ? CTI_END : CTI_INC, BTE_FOUR);
            set_s(1, 0, 0);
            #1;
            check("burst grant_o", grant_o, 2'b01);
            check("burst m_ack_o", m_ack_o, 2'b01);
            nxt();
        end
        set_m(0, 1, 1, 0, 10'h014, CTI_CLASSIC, BTE_LINEAR);
        set_s(0, 0, 0);
        #1;
        check("burst rel grant_o", grant_o, 2'b00);
        nxt();
        nxt();
        #1;
        check("after burst grant_o", grant_o, 2'b10);

        // Back-to-back classic cycles forced off after MAXB acks.
        do_reset();
        set_m(0, 1, 1, 1, 10'h100, CTI_CLASSIC, BTE_LINEAR);
        set_m(1, 1, 1, 0, 10'h200, CTI_CLASSIC, BTE_LINEAR);
        nxt();
        for (int b = 0; b < MAXB; b++) begin
            set_s(1, 0, 0);
            #1;
            check("hold grant_o", grant_o, 2'b01);
            nxt();
        end
        set_s(0, 0, 0);
        #1;
        check("forced grant_o", grant_o, 2'b00);
        nxt();
        nxt();
        #1;
        check("after forced grant_o", grant_o, 2'b10);

        // Reset during the second beat of a burst.
        do_reset();
        set_m(0, 1, 1, 0, 10'h050, CTI_INC, BTE_FOUR);
        nxt();
        set_s(1, 0, 0);
        nxt();
        set_s(1, 0, 0);
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        #1;
        check("post rst grant_o", grant_o, 2'b00);
        check("post rst s_cyc_o", s_cyc_o, 0);
        check("post rst m_ack_o", m_ack_o, 2'b00);
        set_m(0, 0, 0, 0, 10'h050, CTI_CLASSIC, BTE_LINEAR);
        set_m(1, 1, 1, 0, 10'h060, CTI_CLASSIC, BTE_LINEAR);
        set_s(0, 0, 0);
        nxt();
        #1;
        check("m1 alone grant_o", grant_o, 2'b10);

        // Error response while master 1 owns the bus.
        set_s(0, 1, 0);
        #1;
        check("err m_err_o", m_err_o, 2'b10);
        check("err m_ack_o", m_ack_o, 2'b00);
        nxt();
        set_s(0, 0, 0);
        #1;
        check("err hold grant_o", grant_o, 2'b10);
        set_m(1, 0, 0, 0, 10'h060, CTI_CLASSIC, BTE_LINEAR);
        nxt();
        #1;
        check("err rel grant_o", grant_o, 2'b00);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            nxt();
            reset = ($urandom_range(255) == 0);
            for (int i = 0; i < M; i++) begin
                if ($urandom_range(7) == 0) m_cyc[i] = ~m_cyc[i];
                m_stb[i] = m_cyc[i] ? ($urandom_range(3) != 0) : ($urandom_range(7) == 0);
                m_we[i]  = 1'($urandom_range(1));
                m_addr[i*Aw +: Aw]    = Aw'($urandom);
                m_cti[i*CTIw +: CTIw] = cti_tab[$urandom_range(4)];
                m_bte[i*BTEw +: BTEw] = BTEw'($urandom);
                m_sel[i*SELw +: SELw] = SELw'($urandom);
                m_dat[i*Dw +: Dw]     = $urandom;
            end
            s_ack = ($urandom_range(1) == 1);
            s_err = ($urandom_range(15) == 0);
            s_rty = ($urandom_range(15) == 0);
            s_dat = $urandom;
        end
        nxt();
        reset = 1'b0;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
